// File: rtl/quad_gen_pkg.sv
// Shared definitions for the quadrature generator: FSM states, the 2-bit
// Gray phase constants and the helpers that step the phase up or down.
package quad_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Phase order when counting up: 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  // Advance one quarter-cycle in the counting-up direction
  function automatic logic [1:0] next_phase(input logic [1:0] ab);
    case (ab)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      default: return PH0;
    endcase
  endfunction

  // Step one quarter-cycle in the counting-down direction
  function automatic logic [1:0] prev_phase(input logic [1:0] ab);
    case (ab)
      PH0:     return PH3;
      PH3:     return PH2;
      PH2:     return PH1;
      default: return PH0;
    endcase
  endfunction

endpackage

// File: rtl/quad_gen_pacer.sv
// Edge pacer: while enabled, emits a one-cycle tick every EDGE_DIV clocks.
// The count is held at zero while disabled, so every enable rise starts a
// fresh interval and the first tick lands EDGE_DIV cycles after the rise.
module quad_gen_pacer #(
  parameter int unsigned EDGE_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(EDGE_DIV - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next count: clear while disabled, wrap after the last cycle of an interval
  always_comb begin
    count_d = count_q;
    if (!enable_i) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + 16'd1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/quad_gen.sv
// Quadrature encoder emulator: accepts step commands and emits Gray-coded
// A/B edges at a fixed pace while tracking a wrapping signed position.
// Optional index output enabled by defining QUAD_GEN_INDEX_EN; otherwise
// enc_z is tied low and no index logic exists.
module quad_gen
  import quad_gen_pkg::*;
#(
  parameter int unsigned EDGE_DIV     = 4,
  parameter int unsigned POS_WIDTH    = 16,
  parameter int unsigned INDEX_PERIOD = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_dir,
  input  logic [15:0]                 cmd_steps,
  input  logic                        cmd_abort,
  output logic                        enc_a,
  output logic                        enc_b,
  output logic                        enc_z,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        busy,
  output logic                        done
);

  state_e               state_q;
  logic                 dir_q;
  logic [15:0]          steps_q;
  logic [1:0]           ab_q;
  logic [POS_WIDTH-1:0] pos_q;
  logic                 done_q;
  logic                 tick;
  logic [1:0]           step_ab;
  logic [POS_WIDTH-1:0] step_pos;

  quad_gen_pacer #(
    .EDGE_DIV(EDGE_DIV)
  ) u_pacer (
    .clk     (clk),
    .rst     (rst),
    .enable_i(state_q == RUN),
    .tick_o  (tick)
  );

  assign step_ab  = dir_q ? next_phase(ab_q) : prev_phase(ab_q);
  assign step_pos = dir_q ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);

  // Command FSM: accept in IDLE, emit one edge per pacer tick in RUN,
  // leave RUN on the final edge or on abort (an edge on the abort cycle
  // still goes out), pulsing done for one cycle either way
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      steps_q <= '0;
      ab_q    <= PH0;
      pos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_steps == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              dir_q   <= cmd_dir;
              steps_q <= cmd_steps;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (tick) begin
            ab_q    <= step_ab;
            pos_q   <= step_pos;
            steps_q <= steps_q - 16'd1;
            if (steps_q == 16'd1) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          if (cmd_abort) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef QUAD_GEN_INDEX_EN
  localparam logic [POS_WIDTH-1:0] IDX_MASK = POS_WIDTH'(INDEX_PERIOD - 1);

  logic z_q;

  // Index flag recomputed with every emitted edge from the new position/phase
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q <= 1'b0;
    end else if ((state_q == RUN) && tick) begin
      z_q <= ((step_pos & IDX_MASK) == '0) && (step_ab == PH0);
    end
  end

  assign enc_z = z_q;
`else
  assign enc_z = 1'b0;
`endif

  assign enc_a     = ab_q[1];
  assign enc_b     = ab_q[0];
  assign position  = pos_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN);
  assign cmd_ready = (state_q == IDLE);

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen. Observations are packed as
// {enc_a, enc_b, position, busy, done, cmd_ready, enc_z} and sampled on the
// falling edge. The reference model derives A/B from position mod 4 and
// position from the count of edges due at multiples of EDGE_DIV.
module tb_quad_gen;

  localparam int D  = 4;
`ifdef QUAD_GEN_INDEX_EN
  localparam int IP = 4;
`else
  localparam int IP = 256;
`endif

  logic               clk;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [15:0]        cmd_steps;
  logic               cmd_abort;
  logic               enc_a;
  logic               enc_b;
  logic               enc_z;
  logic signed [15:0] position;
  logic               busy;
  logic               done;

  int checks;
  int errors;
  int model_pos;
  bit model_z;

  quad_gen #(
    .EDGE_DIV    (D),
    .POS_WIDTH   (16),
    .INDEX_PERIOD(IP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_abort(cmd_abort),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .enc_z    (enc_z),
    .position (position),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quadrature phase for a given count (count-up order 00,01,11,10)
  function automatic logic [1:0] gray_of(input int p);
    logic [1:0] tbl [4];
    tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b11; tbl[3] = 2'b10;
    return tbl[p % 4];
  endfunction

  // Position within the 4-phase cycle, used by the reference decoder
  function automatic int idx_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Reference decoder: +1 for an up edge, -1 for a down edge, 0 otherwise
  function automatic int decode(input logic [1:0] prev, input logic [1:0] cur);
    int d;
    d = (idx_of(cur) - idx_of(prev) + 4) % 4;
    if (d == 1) return 1;
    if (d == 3) return -1;
    return 0;
  endfunction

  function automatic bit exp_z(input int p);
`ifdef QUAD_GEN_INDEX_EN
    return ((p % IP) == 0) && ((p % 4) == 0);
`else
    return (p < 0);
`endif
  endfunction

  function automatic int wrap16(input int p);
    return ((p % 65536) + 65536) % 65536;
  endfunction

  function automatic logic [21:0] expect_vec(input int p, input bit b, input bit d, input bit z);
    return {gray_of(p), 16'(p), b, d, ~b, z};
  endfunction

  function automatic logic [21:0] sample_obs();
    return {enc_a, enc_b, position, busy, done, cmd_ready, enc_z};
  endfunction

  // Reset must clear everything and hold while asserted, synchronously
  task automatic test_reset();
    logic [21:0] obs;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    obs = sample_obs();
    if (obs !== expect_vec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_hold got=%h exp=%h", obs, expect_vec(0, 0, 0, 0));
    end
    checks++;
    rst = 1'b0;
    @(negedge clk);
    obs = sample_obs();
    if (obs !== expect_vec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_release got=%h exp=%h", obs, expect_vec(0, 0, 0, 0));
    end
    checks++;
    model_pos = 0;
    model_z   = 1'b0;
  endtask

  // Up 4 steps from 0: AB 01,11,10,00 at cycles 4,8,12,16, done at 16
  task automatic test_up_four();
    logic [1:0]  ab_tbl [5];
    logic [21:0] obs;
    logic [21:0] expv;
    int          edges;
    bit          zx;
    ab_tbl[0] = 2'b00; ab_tbl[1] = 2'b01; ab_tbl[2] = 2'b11;
    ab_tbl[3] = 2'b10; ab_tbl[4] = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd4;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) @(negedge clk);
      edges = (c > 16) ? 4 : c / 4;
`ifdef QUAD_GEN_INDEX_EN
      zx = (edges == 4);
`else
      zx = 1'b0;
`endif
      expv = {ab_tbl[edges], 16'(edges), (c < 16), (c == 16), (c >= 16), zx};
      obs  = sample_obs();
      if (obs !== expv) begin
        errors++; $display("[TB] FAIL up_four c=%0d got=%h exp=%h", c, obs, expv);
      end
      checks++;
    end
    model_pos = 4;
    model_z   = zx;
  endtask

  // Down 3 steps from 0: AB 10,11,01, position 0xFFFD, decoder reads -3
  task automatic test_down_three();
    logic [1:0]  ab_tbl [4];
    logic [15:0] pos_tbl [4];
    logic [21:0] obs;
    logic [21:0] expv;
    logic [1:0]  prev;
    int          edges;
    int          dec;
    ab_tbl[0] = 2'b00; ab_tbl[1] = 2'b10; ab_tbl[2] = 2'b11; ab_tbl[3] = 2'b01;
    pos_tbl[0] = 16'h0000; pos_tbl[1] = 16'hFFFF;
    pos_tbl[2] = 16'hFFFE; pos_tbl[3] = 16'hFFFD;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    prev = {enc_a, enc_b};
    dec  = 0;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      edges = (c > 12) ? 3 : c / 4;
      dec   = dec + decode(prev, {enc_a, enc_b});
      prev  = {enc_a, enc_b};
      expv  = {ab_tbl[edges], pos_tbl[edges], (c < 12), (c == 12), (c >= 12), 1'b0};
      obs   = sample_obs();
      if (obs !== expv) begin
        errors++; $display("[TB] FAIL down_three c=%0d got=%h exp=%h", c, obs, expv);
      end
      checks++;
    end
    if (dec !== -3) begin
      errors++; $display("[TB] FAIL down_three_decoder got=%0d exp=-3", dec);
    end
    checks++;
    model_pos = 65533;
    model_z   = 1'b0;
  endtask

  // Zero-step command: accepted, no motion, done pulses on the next cycle
  task automatic test_zero_steps();
    logic [21:0] obs;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    obs = sample_obs();
    if (obs !== expect_vec(model_pos, 0, 1, model_z)) begin
      errors++; $display("[TB] FAIL zero_steps_done got=%h exp=%h", obs, expect_vec(model_pos, 0, 1, model_z));
    end
    checks++;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      obs = sample_obs();
      if (obs !== expect_vec(model_pos, 0, 0, model_z)) begin
        errors++; $display("[TB] FAIL zero_steps_idle c=%0d got=%h exp=%h", c, obs, expect_vec(model_pos, 0, 0, model_z));
      end
      checks++;
    end
  endtask

  // 10-step command aborted after 2 edges: frozen, done, ready again
  task automatic test_abort_two_edges();
    logic [21:0] obs;
    logic [21:0] expv;
    int          start;
    int          edges;
    int          p;
    bit          zx;
    start = model_pos;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      edges = (c >= 9) ? 2 : c / 4;
      p     = wrap16(start + edges);
      zx    = (edges > 0) ? exp_z(p) : model_z;
      expv  = expect_vec(p, (c < 9), (c == 9), zx);
      obs   = sample_obs();
      if (obs !== expv) begin
        errors++; $display("[TB] FAIL abort_two c=%0d got=%h exp=%h", c, obs, expv);
      end
      checks++;
      cmd_abort = (c == 8);
    end
    cmd_abort = 1'b0;
    model_pos = wrap16(start + 2);
    model_z   = exp_z(model_pos);
  endtask

  // Random commands with random aborts (inside and outside RUN) and
  // spurious cmd_valid during RUN, compared against the edge-count model
  task automatic test_random();
    logic [21:0] obs;
    logic [21:0] expv;
    logic [1:0]  prev;
    bit          dir;
    int          steps;
    int          abort_at;
    int          fin;
    int          edges;
    int          sgn;
    int          p;
    int          dec;
    int          maxc;
    bit          noise;
    bit          zx;
    for (int n = 0; n < 40; n++) begin
      dir      = 1'($urandom_range(0, 1));
      steps    = $urandom_range(0, 12);
      abort_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, steps * D + 4) : 100000;
      noise    = 1'($urandom_range(0, 1));
      sgn      = dir ? 1 : -1;
      fin      = (steps == 0) ? 0 : ((abort_at < steps * D) ? abort_at : steps * D);
      maxc     = steps * D + 5;
      prev     = {enc_a, enc_b};
      dec      = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = 16'(steps);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int c = 0; c <= maxc; c++) begin
        if (c > 0) @(negedge clk);
        edges = ((c < fin) ? c : fin) / D;
        p     = wrap16(model_pos + sgn * edges);
        zx    = (edges > 0) ? exp_z(p) : model_z;
        expv  = expect_vec(p, (c < fin), (c == fin), zx);
        obs   = sample_obs();
        dec   = dec + decode(prev, {enc_a, enc_b});
        prev  = {enc_a, enc_b};
        if (obs !== expv) begin
          errors++; $display("[TB] FAIL random n=%0d c=%0d got=%h exp=%h", n, c, obs, expv);
        end
        checks++;
        cmd_abort = (c + 1 == abort_at);
        cmd_valid = noise && (c + 1 < fin) && ($urandom_range(0, 1) == 1);
        cmd_dir   = 1'($urandom_range(0, 1));
        cmd_steps = 16'($urandom_range(0, 20));
      end
      cmd_valid = 1'b0;
      cmd_abort = 1'b0;
      edges = fin / D;
      if (dec !== sgn * edges) begin
        errors++; $display("[TB] FAIL random_decoder n=%0d got=%0d exp=%0d", n, dec, sgn * edges);
      end
      checks++;
      model_pos = wrap16(model_pos + sgn * edges);
      if (edges > 0) model_z = exp_z(model_pos);
    end
  endtask

  // Reset in the middle of a run discards the command and zeroes outputs
  task automatic test_reset_during_run();
    logic [21:0] obs;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    obs = sample_obs();
    if (obs !== expect_vec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_in_run got=%h exp=%h", obs, expect_vec(0, 0, 0, 0));
    end
    checks++;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    obs = sample_obs();
    if (obs !== expect_vec(0, 0, 0, 0)) begin
      errors++; $display("[TB] FAIL reset_in_run_after got=%h exp=%h", obs, expect_vec(0, 0, 0, 0));
    end
    checks++;
    model_pos = 0;
    model_z   = 1'b0;
  endtask

  // Test sequence
  initial begin
    checks    = 0;
    errors    = 0;
    model_pos = 0;
    model_z   = 1'b0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = 16'd0;
    cmd_abort = 1'b0;
    test_reset();
    test_up_four();
    test_down_three();
    test_zero_steps();
    test_abort_two_edges();
    test_random();
    test_reset_during_run();
    test_up_four();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
